// File: rtl/pulp_clock_gating_ctrl_if.sv
// Handshake bundle between the clock-gating controller and its environment.
// Signals: busy_i (activity request), en_ack_i (async ack from remote gate),
//          en_async_o (gate enable request), clk_on_o (clock confirmed), err_o.
interface pulp_clock_gating_ctrl_if;
  logic busy_i;
  logic en_ack_i;
  logic en_async_o;
  logic clk_on_o;
  logic err_o;

  // Controller side.
  modport slave (
    input  busy_i,
    input  en_ack_i,
    output en_async_o,
    output clk_on_o,
    output err_o
  );

  // Environment side: consumers plus the remote clock gate.
  modport master (
    output busy_i,
    output en_ack_i,
    input  en_async_o,
    input  clk_on_o,
    input  err_o
  );
endinterface

// File: rtl/pulp_clock_gating_ctrl.sv
// Purpose: request/acknowledge controller for a remote asynchronous clock gate.
//   Wakes the gate on busy_i, confirms via a synchronized ack, gates the clock
//   off after IDLE_CYCLES+1 idle samples, and waits for the ack to drop.
// Ports: clk_i, rst_i (sync, active-high); bus (slave modport): busy_i,
//   en_ack_i (async), en_async_o, clk_on_o, err_o. All outputs registered.
// Optional watchdog: define CLOCK_GATING_CTRL_TIMEOUT_EN to enable err_o.
module pulp_clock_gating_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  pulp_clock_gating_ctrl_if.slave   bus
);

  // Elaboration-time legality checks on the parameters.
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (IDLE_CYCLES < 1) begin : g_chk_idle
    $error("IDLE_CYCLES must be >= 1");
  end
  if (ACK_TIMEOUT < 2) begin : g_chk_to
    $error("ACK_TIMEOUT must be >= 2");
  end

  localparam int CNT_W = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    WAKE  = 3'd1,
    ON    = 3'd2,
    DRAIN = 3'd3,
    SLEEP = 3'd4
  } state_t;

  state_t                 state;
  logic                   en_q;
  logic                   on_q;
  logic [CNT_W-1:0]       idle_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  // Ack synchronizer; only its last stage is ever looked at.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.en_ack_i};
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  // Controller FSM. Outputs are assigned together with the transition so they
  // reflect the new state in the same cycle the state register does.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= OFF;
      en_q     <= 1'b0;
      on_q     <= 1'b0;
      idle_cnt <= '0;
    end else begin
      case (state)
        OFF: begin
          if (bus.busy_i) begin
            state <= WAKE;
            en_q  <= 1'b1;
          end
        end
        // No abort while waiting: the gate must finish turning on first.
        WAKE: begin
          if (ack_s) begin
            state <= ON;
            on_q  <= 1'b1;
          end
        end
        ON: begin
          if (!bus.busy_i) begin
            state    <= DRAIN;
            idle_cnt <= IDLE_LOAD;
          end
        end
        // The cycle spent in ON plus IDLE_CYCLES cycles here gives the
        // IDLE_CYCLES+1 idle samples before the enable drops.
        DRAIN: begin
          if (bus.busy_i) begin
            state    <= ON;
            idle_cnt <= '0;
          end else if (idle_cnt == '0) begin
            state <= SLEEP;
            en_q  <= 1'b0;
            on_q  <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt - 1'b1;
          end
        end
        // Wait for the gate to confirm off so on/off requests never overlap.
        SLEEP: begin
          if (!ack_s) begin
            state <= OFF;
          end
        end
        default: begin
          state    <= OFF;
          en_q     <= 1'b0;
          on_q     <= 1'b0;
          idle_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.en_async_o = en_q;
  assign bus.clk_on_o   = on_q;

`ifdef CLOCK_GATING_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(ACK_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(ACK_TIMEOUT - 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;
  logic            waiting;

  // Any cycle outside WAKE/SLEEP clears the count, so it restarts at zero
  // on every entry to a handshake wait.
  assign waiting = (state == WAKE) || (state == SLEEP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else if (!waiting) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_LIMIT) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      // Flag raised on the edge where the count reaches the limit; sticky.
      if (wd_cnt == WD_LAST) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_pulp_clock_gating_ctrl.sv
module tb_pulp_clock_gating_ctrl;

  localparam int SYNC = 2;
  localparam int IDLE = 4;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_mode = 1'b0;
  logic ack_man = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  pulp_clock_gating_ctrl_if bus ();

  // The remote gate is either modelled as an instant loopback or driven by hand.
  assign bus.en_ack_i = loop_mode ? bus.en_async_o : ack_man;

  pulp_clock_gating_ctrl #(
    .SYNC_STAGES (SYNC),
    .IDLE_CYCLES (IDLE),
    .ACK_TIMEOUT (TO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic busy;
    logic ack;
    logic en;
    logic on;
  } vec_t;

  // Inputs applied before an edge, outputs expected just after it.
  vec_t tbl [22] = '{
    '{0,0,0,0}, '{0,1,0,0}, '{0,0,0,0}, '{1,0,1,0}, '{0,0,1,0}, '{0,1,1,0},
    '{0,1,1,0}, '{1,1,1,1}, '{1,1,1,1}, '{0,1,1,1}, '{0,0,1,1}, '{1,1,1,1},
    '{0,1,1,1}, '{0,1,1,1}, '{0,1,1,1}, '{0,1,1,1}, '{0,1,0,0}, '{1,1,0,0},
    '{1,0,0,0}, '{1,0,0,0}, '{1,0,0,0}, '{1,0,1,0}
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.busy_i = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Reference model state: gate requested, clock confirmed, gate confirmed off,
  // length of the current idle run while confirmed, and enable history seen
  // through the loopback + synchronizer delay.
  logic m_en, m_on, m_off_ok;
  int   m_idle;
  logic m_hist [$];

  task automatic model_reset();
    m_en = 1'b0;
    m_on = 1'b0;
    m_off_ok = 1'b1;
    m_idle = 0;
    m_hist = {};
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
  endtask

  task automatic model_step(input logic b);
    logic ack_s;
    ack_s = m_hist.pop_front();
    m_hist.push_back(m_en);
    if (!m_en) begin
      if (!m_off_ok) begin
        if (!ack_s) m_off_ok = 1'b1;
      end else if (b) begin
        m_en = 1'b1;
      end
    end else if (!m_on) begin
      if (ack_s) begin
        m_on = 1'b1;
        m_idle = 0;
      end
    end else begin
      m_idle = b ? 0 : m_idle + 1;
      if (m_idle == IDLE + 1) begin
        m_en = 1'b0;
        m_on = 1'b0;
        m_off_ok = 1'b0;
        m_idle = 0;
      end
    end
  endtask

  initial begin
    int cnt;
    int p;
    logic b;
    bus.busy_i = 1'b0;

    // Reset state.
    do_reset();
    chk("reset_en", bus.en_async_o, 1'b0);
    chk("reset_on", bus.clk_on_o, 1'b0);
    chk("reset_err", bus.err_o, 1'b0);

    // Table: manual ack, full OFF->WAKE->ON->DRAIN->ON->DRAIN->SLEEP->OFF->WAKE.
    for (int i = 0; i < 22; i++) begin
      bus.busy_i = tbl[i].busy;
      ack_man = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_en", i), bus.en_async_o, tbl[i].en);
      chk($sformatf("tbl%0d_on", i), bus.clk_on_o, tbl[i].on);
      chk($sformatf("tbl%0d_err", i), bus.err_o, 1'b0);
    end

    // Reset while waiting in WAKE drops the request at once.
    rst = 1'b1;
    tick();
    chk("rst_wake_en", bus.en_async_o, 1'b0);
    chk("rst_wake_on", bus.clk_on_o, 1'b0);
    chk("rst_wake_err", bus.err_o, 1'b0);
    rst = 1'b0;
    bus.busy_i = 1'b0;
    ack_man = 1'b0;
    tick();
    chk("rst_wake_stays_off", bus.en_async_o, 1'b0);

    // Loopback wake latency and idle gate-off timing.
    loop_mode = 1'b1;
    do_reset();
    bus.busy_i = 1'b1;
    tick();
    chk("wake_en_1cyc", bus.en_async_o, 1'b1);
    tick();
    tick();
    chk("wake_on_3cyc", bus.clk_on_o, 1'b0);
    tick();
    chk("wake_on_4cyc", bus.clk_on_o, 1'b1);
    tick();
    bus.busy_i = 1'b0;
    for (int i = 1; i <= IDLE; i++) begin
      tick();
      chk($sformatf("idle_en_t%0d", i), bus.en_async_o, 1'b1);
    end
    tick();
    chk("idle_en_fall", bus.en_async_o, 1'b0);
    chk("idle_on_fall", bus.clk_on_o, 1'b0);

    // busy re-asserted during SLEEP; ack held high 5 cycles then dropped.
    loop_mode = 1'b0;
    ack_man = 1'b0;
    do_reset();
    bus.busy_i = 1'b1;
    tick();
    ack_man = 1'b1;
    tick();
    tick();
    tick();
    chk("slp_on_reached", bus.clk_on_o, 1'b1);
    bus.busy_i = 1'b0;
    for (int i = 0; i < IDLE + 1; i++) tick();
    chk("slp_entered", bus.en_async_o, 1'b0);
    bus.busy_i = 1'b1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      cnt++;
      chk($sformatf("slp_hold_en%0d", i), bus.en_async_o, 1'b0);
    end
    ack_man = 1'b0;
    begin
      int k;
      k = 0;
      while (bus.en_async_o !== 1'b1 && k < 30) begin
        tick();
        cnt++;
        k++;
      end
      if (k >= 30) begin
        n_cmp++;
        n_bad++;
        $display("FAIL slp_rewake: en_async_o still %0b after 30 cycles, expected 1", bus.en_async_o);
      end else begin
        n_cmp++;
        if (cnt != 5 + SYNC + 2) begin
          n_bad++;
          $display("FAIL slp_low_cycles: got %0d expected %0d", cnt, 5 + SYNC + 2);
        end
      end
    end
    chk("slp_rewake_on", bus.clk_on_o, 1'b0);

    // Ack never arrives: FSM keeps waiting; watchdog behaviour depends on build.
    ack_man = 1'b0;
    do_reset();
    bus.busy_i = 1'b1;
    tick();
    bus.busy_i = 1'b0;
`ifdef CLOCK_GATING_CTRL_TIMEOUT_EN
    for (int i = 1; i < TO; i++) tick();
    chk("to_err_before", bus.err_o, 1'b0);
    tick();
    chk("to_err_set", bus.err_o, 1'b1);
    chk("to_still_wake", bus.en_async_o, 1'b1);
    ack_man = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("to_late_ack_on", bus.clk_on_o, 1'b1);
    chk("to_err_sticky", bus.err_o, 1'b1);
    do_reset();
    chk("to_err_cleared", bus.err_o, 1'b0);
`else
    for (int i = 0; i < 3 * TO; i++) tick();
    chk("noto_err", bus.err_o, 1'b0);
    chk("noto_wait_en", bus.en_async_o, 1'b1);
    chk("noto_wait_on", bus.clk_on_o, 1'b0);
`endif

    // Randomized busy traffic with looped-back ack against the model.
    loop_mode = 1'b1;
    do_reset();
    model_reset();
    p = 50;
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) begin
        case ($urandom_range(0, 2))
          0: p = 10;
          1: p = 50;
          default: p = 90;
        endcase
      end
      b = ($urandom_range(0, 99) < p) ? 1'b1 : 1'b0;
      bus.busy_i = b;
      model_step(b);
      tick();
      chk($sformatf("rnd%0d_en", n), bus.en_async_o, m_en);
      chk($sformatf("rnd%0d_on", n), bus.clk_on_o, m_on);
      chk($sformatf("rnd%0d_err", n), bus.err_o, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
